// File: rtl/uart_imem_loader.sv
// Purpose: boot loader that receives a length-prefixed program image over UART (8N1) and writes it into instruction memory.
// Latency: stop-bit sample -> IMEM_WE is 1 cycle; final IMEM_WE -> CORE_RESET low / BOOT_DONE high is 1 cycle.
// Backpressure: none; the serial line cannot be stalled, so every accepted byte is consumed on the cycle it completes.
//
// Ports:
//   CLK, RST      system clock (rising edge) and asynchronous active-high reset
//   UART_RX       serial input, idle high, 8N1, LSB first
//   IMEM_ADDR     instruction memory word address (holds between writes)
//   IMEM_WDATA    instruction memory write data (holds between writes)
//   IMEM_WE       single-cycle write strobe
//   CORE_RESET    high while the image is still loading
//   BOOT_DONE     sticky, high once the whole image has been written
//   FRAME_ERR     sticky, set by any byte whose stop bit sampled low
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_RX,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [DATA_W-1:0] IMEM_WDATA,
    output logic              IMEM_WE,
    output logic              CORE_RESET,
    output logic              BOOT_DONE,
    output logic              FRAME_ERR
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int LEN_W     = ADDR_W + 1;
    localparam int MAX_WORDS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, DONE} ld_state_t;

    // ---------------- state ----------------
    logic              rx_s1_q, rx_s2_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              frame_err_q, frame_err_d;

    ld_state_t         ld_state_q, ld_state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_W-9:0] asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              core_reset_q, core_reset_d;
    logic              boot_done_q, boot_done_d;

    logic              rx_sync;
    logic              byte_vld;
    logic [15:0]       len_full;

    assign rx_sync = rx_s2_q;

    // ---------------- UART receiver ----------------
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        frame_err_d = frame_err_q;
        byte_vld    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: a line that has gone high again was a glitch.
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_FULL) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Return to idle right at the stop sample so a back-to-back
                // start bit is not missed.
                if (rx_cnt_q == CNT_FULL) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync) begin
                        byte_vld = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- image loader ----------------
    always_comb begin
        ld_state_d   = ld_state_q;
        len_lo_d     = len_lo_q;
        count_d      = count_q;
        wcnt_d       = wcnt_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        core_reset_d = core_reset_q;
        boot_done_d  = boot_done_q;
        len_full     = {rx_shift_q, len_lo_q};
        case (ld_state_q)
            LEN_LO: begin
                if (byte_vld) begin
                    len_lo_d   = rx_shift_q;
                    ld_state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byte_vld) begin
                    if (len_full == 16'd0) begin
                        ld_state_d   = DONE;
                        core_reset_d = 1'b0;
                        boot_done_d  = 1'b1;
                    end else begin
                        // The image can never exceed the memory depth.
                        if (32'(len_full) > MAX_WORDS) begin
                            count_d = LEN_W'(MAX_WORDS);
                        end else begin
                            count_d = LEN_W'(len_full);
                        end
                        wcnt_d     = '0;
                        byte_idx_d = '0;
                        ld_state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Strobe cycle: the address moves on only after the write.
                if (we_q) begin
                    addr_d = addr_q + 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == count_q) begin
                        ld_state_d   = DONE;
                        core_reset_d = 1'b0;
                        boot_done_d  = 1'b1;
                    end
                end
                // Little-endian assembly: earlier bytes shift toward bit 0.
                if (byte_vld) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_shift_q, asm_q};
                    end else begin
                        asm_d = {rx_shift_q, asm_q[DATA_W-9:8]};
                    end
                end
            end
            DONE: begin
                // Terminal until RST; further serial traffic is ignored.
            end
            default: ld_state_d = LEN_LO;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= LEN_LO;
            len_lo_q     <= '0;
            count_q      <= '0;
            wcnt_q       <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            core_reset_q <= 1'b1;
            boot_done_q  <= 1'b0;
        end else begin
            rx_s1_q      <= UART_RX;
            rx_s2_q      <= rx_s1_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            len_lo_q     <= len_lo_d;
            count_q      <= count_d;
            wcnt_q       <= wcnt_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            core_reset_q <= core_reset_d;
            boot_done_q  <= boot_done_d;
        end
    end

    assign IMEM_ADDR  = addr_q;
    assign IMEM_WDATA = wdata_q;
    assign IMEM_WE    = we_q;
    assign CORE_RESET = core_reset_q;
    assign BOOT_DONE  = boot_done_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Purpose: directed self-checking bench for uart_imem_loader.
// Latency: write and release timing are measured in cycles against the serial stimulus.
// Backpressure: not applicable; the bench drives the serial line at a fixed bit rate.
module tb_uart_imem_loader;

    localparam int CPB = 8;
    // A 16-word memory keeps the over-length image case short while still
    // exercising clamping and address wrap.
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int NW  = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          UART_RX = 1'b1;
    logic [AW-1:0] IMEM_ADDR;
    logic [DW-1:0] IMEM_WDATA;
    logic          IMEM_WE;
    logic          CORE_RESET;
    logic          BOOT_DONE;
    logic          FRAME_ERR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cyc = -1;
    int fall_cyc = -1;
    int done_cyc = -1;
    int we_long = 0;
    int stop_cyc = 0;
    logic we_prev = 1'b0;
    logic cr_prev = 1'b1;
    logic bd_prev = 1'b0;
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .UART_RX(UART_RX),
        .IMEM_ADDR(IMEM_ADDR),
        .IMEM_WDATA(IMEM_WDATA),
        .IMEM_WE(IMEM_WE),
        .CORE_RESET(CORE_RESET),
        .BOOT_DONE(BOOT_DONE),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Write log and edge timestamps, sampled mid-cycle.
    always @(negedge CLK) begin
        if (IMEM_WE === 1'b1) begin
            wr_addr.push_back(IMEM_ADDR);
            wr_data.push_back(IMEM_WDATA);
            we_cyc = cyc;
            if (we_prev === 1'b1) we_long++;
        end
        if (cr_prev === 1'b1 && CORE_RESET === 1'b0) fall_cyc = cyc;
        if (bd_prev === 1'b0 && BOOT_DONE === 1'b1) done_cyc = cyc;
        we_prev = IMEM_WE;
        cr_prev = CORE_RESET;
        bd_prev = BOOT_DONE;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        UART_RX = 1'b1;
        repeat (2) @(negedge CLK);
        wr_addr.delete();
        wr_data.delete();
        we_cyc = -1;
        fall_cyc = -1;
        done_cyc = -1;
        we_long = 0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    // One 8N1 frame; stop_cyc records when the stop bit went onto the line.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        UART_RX = stop;
        stop_cyc = cyc;
        repeat (CPB) @(negedge CLK);
        UART_RX = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        UART_RX = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (IMEM_ADDR !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", IMEM_ADDR); end
        checks++; if (IMEM_WDATA !== '0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", IMEM_WDATA); end
        checks++; if (IMEM_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", IMEM_WE); end
        checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %0b want 1", CORE_RESET); end
        checks++; if (BOOT_DONE !== 1'b0) begin errors++; $display("FAIL reset_boot_done: got %0b want 0", BOOT_DONE); end
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b want 0", FRAME_ERR); end
        RST = 1'b0;
        idle(4 * CPB);
        checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL idle_core_reset: got %0b want 1", CORE_RESET); end
        checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL idle_writes: got %0d want 0", wr_data.size()); end
    endtask

    task automatic test_two_words();
        logic [7:0] img [10];
        logic [DW-1:0] d0, d1;
        logic [AW-1:0] a0, a1;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
        idle(2 * CPB);
        d0 = (wr_data.size() > 0) ? wr_data[0] : 'x;
        d1 = (wr_data.size() > 1) ? wr_data[1] : 'x;
        a0 = (wr_addr.size() > 0) ? wr_addr[0] : 'x;
        a1 = (wr_addr.size() > 1) ? wr_addr[1] : 'x;
        checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL two_count: got %0d want 2", wr_data.size()); end
        checks++; if (a0 !== 4'd0) begin errors++; $display("FAIL two_addr0: got %0h want 0", a0); end
        checks++; if (d0 !== 32'h00500513) begin errors++; $display("FAIL two_data0: got %08h want 00500513", d0); end
        checks++; if (a1 !== 4'd1) begin errors++; $display("FAIL two_addr1: got %0h want 1", a1); end
        checks++; if (d1 !== 32'h000000B3) begin errors++; $display("FAIL two_data1: got %08h want 000000b3", d1); end
        checks++; if (!(we_cyc > stop_cyc && we_cyc <= stop_cyc + CPB)) begin errors++; $display("FAIL two_we_timing: got cycle %0d want within (%0d,%0d]", we_cyc, stop_cyc, stop_cyc + CPB); end
        checks++; if (fall_cyc !== we_cyc + 1) begin errors++; $display("FAIL two_release: got cycle %0d want %0d", fall_cyc, we_cyc + 1); end
        checks++; if (done_cyc !== we_cyc + 1) begin errors++; $display("FAIL two_done_cycle: got cycle %0d want %0d", done_cyc, we_cyc + 1); end
        checks++; if (CORE_RESET !== 1'b0) begin errors++; $display("FAIL two_core_reset: got %0b want 0", CORE_RESET); end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL two_boot_done: got %0b want 1", BOOT_DONE); end
        checks++; if (we_long != 0) begin errors++; $display("FAIL two_we_width: got %0d long strobes want 0", we_long); end
        for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1), 1'b1);
        idle(2 * CPB);
        checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL two_after_done: got %0d writes want 2", wr_data.size()); end
        checks++; if (IMEM_WDATA !== 32'h000000B3) begin errors++; $display("FAIL two_wdata_hold: got %08h want 000000b3", IMEM_WDATA); end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL two_done_sticky: got %0b want 1", BOOT_DONE); end
    endtask

    task automatic test_zero_count();
        do_reset();
        send_byte(8'h00, 1'b1);
        checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL zero_early_release: got %0b want 1", CORE_RESET); end
        send_byte(8'h00, 1'b1);
        idle(2 * CPB);
        checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_data.size()); end
        checks++; if (CORE_RESET !== 1'b0) begin errors++; $display("FAIL zero_core_reset: got %0b want 0", CORE_RESET); end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL zero_boot_done: got %0b want 1", BOOT_DONE); end
        checks++; if (!(fall_cyc > stop_cyc && fall_cyc <= stop_cyc + CPB)) begin errors++; $display("FAIL zero_release_timing: got cycle %0d want within (%0d,%0d]", fall_cyc, stop_cyc, stop_cyc + CPB); end
    endtask

    task automatic test_frame_err();
        logic [DW-1:0] d0;
        logic [AW-1:0] a0;
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL ferr_before: got %0b want 0", FRAME_ERR); end
        send_byte(8'h55, 1'b0);
        idle(2 * CPB);
        checks++; if (FRAME_ERR !== 1'b1) begin errors++; $display("FAIL ferr_set: got %0b want 1", FRAME_ERR); end
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        idle(2 * CPB);
        d0 = (wr_data.size() > 0) ? wr_data[0] : 'x;
        a0 = (wr_addr.size() > 0) ? wr_addr[0] : 'x;
        checks++; if (wr_data.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", wr_data.size()); end
        checks++; if (a0 !== 4'd0) begin errors++; $display("FAIL ferr_addr: got %0h want 0", a0); end
        checks++; if (d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL ferr_data: got %08h want deadbeef", d0); end
        checks++; if (FRAME_ERR !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %0b want 1", FRAME_ERR); end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL ferr_boot_done: got %0b want 1", BOOT_DONE); end
    endtask

    task automatic test_glitch();
        logic [DW-1:0] d0;
        do_reset();
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL glitch_ferr_cleared: got %0b want 0", FRAME_ERR); end
        UART_RX = 1'b0;
        repeat (2) @(negedge CLK);
        UART_RX = 1'b1;
        idle(3 * CPB);
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %0b want 0", FRAME_ERR); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(2 * CPB);
        d0 = (wr_data.size() > 0) ? wr_data[0] : 'x;
        checks++; if (wr_data.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", wr_data.size()); end
        checks++; if (d0 !== 32'h12345678) begin errors++; $display("FAIL glitch_data: got %08h want 12345678", d0); end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL glitch_boot_done: got %0b want 1", BOOT_DONE); end
        checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL glitch_ferr_end: got %0b want 0", FRAME_ERR); end
    endtask

    task automatic test_clamp();
        int bad;
        do_reset();
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        for (int w = 0; w < NW; w++) begin
            send_byte(8'(w), 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            checks++; if (BOOT_DONE !== 1'b0) begin errors++; $display("FAIL clamp_early_done word %0d: got %0b want 0", w, BOOT_DONE); end
            send_byte(8'h00, 1'b1);
        end
        idle(2 * CPB);
        checks++; if (wr_data.size() != NW) begin errors++; $display("FAIL clamp_count: got %0d want %0d", wr_data.size(), NW); end
        bad = 0;
        for (int w = 0; w < NW && w < wr_data.size(); w++) begin
            checks++;
            if (wr_addr[w] !== AW'(w) || wr_data[w] !== DW'(w)) begin
                errors++;
                $display("FAIL clamp_write %0d: got addr %0h data %08h want addr %0h data %08h", w, wr_addr[w], wr_data[w], w, w);
            end
        end
        checks++; if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL clamp_boot_done: got %0b want 1", BOOT_DONE); end
        checks++; if (fall_cyc !== we_cyc + 1) begin errors++; $display("FAIL clamp_release: got cycle %0d want %0d", fall_cyc, we_cyc + 1); end
        checks++; if (IMEM_ADDR !== '0) begin errors++; $display("FAIL clamp_addr_wrap: got %0h want 0", IMEM_ADDR); end
        checks++; if (we_long != 0) begin errors++; $display("FAIL clamp_we_width: got %0d long strobes want 0", we_long); end
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b1);
        idle(2 * CPB);
        checks++; if (wr_data.size() != NW) begin errors++; $display("FAIL clamp_after_done: got %0d writes want %0d", wr_data.size(), NW); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d0;
        logic [AW-1:0] a0;
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (CORE_RESET !== 1'b1) begin errors++; $display("FAIL mid_core_reset: got %0b want 1", CORE_RESET); end
        checks++; if (IMEM_WE !== 1'b0) begin errors++; $display("FAIL mid_we: got %0b want 0", IMEM_WE); end
        checks++; if (IMEM_ADDR !== '0 || IMEM_WDATA !== '0) begin errors++; $display("FAIL mid_addr_data: got %0h/%08h want 0/0", IMEM_ADDR, IMEM_WDATA); end
        checks++; if (BOOT_DONE !== 1'b0 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL mid_flags: got done %0b ferr %0b want 0/0", BOOT_DONE, FRAME_ERR); end
        RST = 1'b0;
        idle(2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(2 * CPB);
        d0 = (wr_data.size() > 0) ? wr_data[0] : 'x;
        a0 = (wr_addr.size() > 0) ? wr_addr[0] : 'x;
        checks++; if (wr_data.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", wr_data.size()); end
        checks++; if (a0 !== 4'd0) begin errors++; $display("FAIL mid_addr: got %0h want 0", a0); end
        checks++; if (d0 !== 32'h11223344) begin errors++; $display("FAIL mid_data: got %08h want 11223344", d0); end
        checks++; if (BOOT_DONE !== 1'b1 || CORE_RESET !== 1'b0) begin errors++; $display("FAIL mid_done: got done %0b core_reset %0b want 1/0", BOOT_DONE, CORE_RESET); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_frame_err();
        test_glitch();
        test_clamp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Boot-time stage directly upstream of the Main core.
- Receives a program image over a UART RX line and assembles it into 32-bit words.
- Writes the words into the core's instruction memory at consecutive 10-bit word addresses.
- Holds the core in reset until the whole image is loaded, then releases it.

Parameters:
- CLKS_PER_BIT, 217, CLK cycles per UART bit (25 MHz / 115200). Benches override it to 8.
- ADDR_W, 10, instruction memory word-address width.
- DATA_W, 32, instruction word width. Fixed at 4 bytes.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- UART_RX  in  1  serial input, idle high, 8N1, LSB first.
- IMEM_ADDR  out  ADDR_W  instruction memory write word address.
- IMEM_WDATA  out  DATA_W  instruction memory write data.
- IMEM_WE  out  1  single-cycle write strobe.
- CORE_RESET  out  1  high holds Main in reset.
- BOOT_DONE  out  1  high once loading is complete. Sticky until RST.
- FRAME_ERR  out  1  sticky stop-bit error flag.

Behaviour:
- Reset (async assert, sync release): IMEM_ADDR=0, IMEM_WDATA=0, IMEM_WE=0, CORE_RESET=1, BOOT_DONE=0, FRAME_ERR=0. FSM goes to LEN_LO; RX FSM goes to RX_IDLE.
- RX path:
  - UART_RX passes through a 2-flop synchronizer. Flops reset to 1.
  - RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on a sampled low.
  - RX_START waits CLKS_PER_BIT/2 cycles and re-samples. If high (glitch), return to RX_IDLE. If low, go to RX_DATA.
  - RX_DATA samples 8 bits, each CLKS_PER_BIT cycles apart, at bit centres, LSB first.
  - RX_STOP samples one bit period later.
  - Stop bit = 1: a one-cycle internal byte_valid pulse with the byte.
  - Stop bit = 0: FRAME_ERR set to 1, byte discarded, return to RX_IDLE.
  - In both cases the next falling edge can be accepted immediately after the stop sample.
- Load FSM states: LEN_LO, LEN_HI, DATA, DONE.
  - LEN_LO: first valid byte becomes count[7:0]. Go to LEN_HI.
  - LEN_HI: second valid byte becomes count[15:8].
    - If count=0, go to DONE.
    - Else if count > 2^ADDR_W (1024), clamp to 1024.
    - Go to DATA.
  - DATA: bytes form a little-endian word (byte 0 -> [7:0] ... byte 3 -> [31:24]).
    - On the 4th byte_valid, the next cycle shows IMEM_WDATA=word and IMEM_WE=1 for exactly one cycle, with IMEM_ADDR = current word index.
    - The cycle after the strobe, IMEM_ADDR increments. It wraps to 0 only after the 1024th write, when the FSM leaves DATA.
    - After `count` writes, go to DONE.
  - DONE: CORE_RESET=0 and BOOT_DONE=1, starting the cycle after the final IMEM_WE (or the cycle after the LEN_HI byte when count=0).
    - All further RX bytes are ignored.
    - IMEM_WE is never asserted again.
- Constraints and error behaviour:
  - A partial word at any time never causes a write.
  - IMEM_ADDR and IMEM_WDATA hold their last values when IMEM_WE=0.
  - FRAME_ERR never aborts loading. Host software decides what to do.
  - RST asserted mid-byte or mid-word discards everything and restarts at LEN_LO with CORE_RESET=1.
- Latency: last stop-bit sample -> IMEM_WE is 1 cycle; IMEM_WE -> CORE_RESET low is 1 cycle.

Test Plan:
- CLKS_PER_BIT=8; send 0x02,0x00 then 0x13,0x05,0x50,0x00, 0xB3,0x00,0x00,0x00.
  - Required: IMEM_WE pulses twice; writes addr 0 = 0x00500513 and addr 1 = 0x000000B3.
  - Then CORE_RESET=0 and BOOT_DONE=1 one cycle after the second strobe.
  - No further IMEM_WE pulses.
- Send count bytes 0x00,0x00.
  - Required: no IMEM_WE pulse; CORE_RESET falls one cycle after the 2nd stop sample.
- Send count 0x01,0x00, then a byte whose stop bit is 0, then four valid bytes 0xEF,0xBE,0xAD,0xDE.
  - Required: FRAME_ERR=1 (sticky); single write at addr 0 = 0xDEADBEEF.
- Drive a 2-cycle low glitch on UART_RX in LEN_LO.
  - Required: no byte accepted, FRAME_ERR stays 0, and a following count of 1 plus one word loads normally.
- Send count 0xFF,0xFF, then 1024 words with word i = i.
  - Required: 1024 strobes at addresses 0..1023; DONE after the 1024th.
  - Bytes sent afterwards produce no writes.
- Assert RST for 1 cycle after 2 of 4 data bytes, then resend count 1 plus word 0x11223344.
  - Required: outputs return to reset values on RST; exactly one write at addr 0 = 0x11223344.
